// File: rtl/sram_sub_ctrl_if.sv
// ----------------------------------------------------------------------------
// sram_sub_ctrl_if
//   Bundles every bus signal around the sub-SRAM read controller: the CPU fetch
//   port, the main SRAM read port, the sub-SRAM bank port and the Flash block
//   reader.
//   modport master : the controller's view (drives strobes and CPU responses)
//   modport slave  : the environment's view (CPU, main SRAM, sub SRAM, Flash)
// ----------------------------------------------------------------------------
interface sram_sub_ctrl_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LOG_SUB   = 2,
  parameter int LOG_DEPTH = 8
);
  // CPU fetch port
  logic                 cpu_re;
  logic [ADDR_W-1:0]    cpu_raddr;
  logic                 cpu_flush;
  logic                 cpu_ready;
  logic                 cpu_rvalid;
  logic [DATA_W-1:0]    cpu_rdata;
  logic                 cpu_rmiss;
  // main SRAM
  logic                 main_re;
  logic [ADDR_W-1:0]    main_addr;
  logic [DATA_W-1:0]    main_rdata;
  // sub SRAM bank
  logic                 sub_re;
  logic [LOG_SUB-1:0]   sub_sel;
  logic [LOG_DEPTH-1:0] sub_addr;
  logic                 sub_we;
  logic [DATA_W-1:0]    sub_wdata;
  logic [DATA_W-1:0]    sub_rdata;
  // Flash block reader
  logic                 flash_req;
  logic [ADDR_W-1:0]    flash_addr;
  logic                 flash_ack;
  logic                 flash_rvalid;
  logic [DATA_W-1:0]    flash_rdata;

  modport master (
    input  cpu_re, cpu_raddr, cpu_flush,
           main_rdata, sub_rdata,
           flash_ack, flash_rvalid, flash_rdata,
    output cpu_ready, cpu_rvalid, cpu_rdata, cpu_rmiss,
           main_re, main_addr,
           sub_re, sub_sel, sub_addr, sub_we, sub_wdata,
           flash_req, flash_addr
  );

  modport slave (
    output cpu_re, cpu_raddr, cpu_flush,
           main_rdata, sub_rdata,
           flash_ack, flash_rvalid, flash_rdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_rmiss,
           main_re, main_addr,
           sub_re, sub_sel, sub_addr, sub_we, sub_wdata,
           flash_req, flash_addr
  );
endinterface

// File: rtl/sram_sub_ctrl.sv
// ----------------------------------------------------------------------------
// sram_sub_ctrl
//   Read controller for the main SRAM plus SUB_NUM sub-SRAM slots. Reads in
//   the main window go straight to main SRAM; all other reads are served from
//   a sub slot caching an aligned SUB_DEPTH-word block. A miss picks a victim
//   with clock (second-chance) replacement, refills it from Flash and replays
//   the lookup.
// Ports
//   clk   : clock
//   grst  : asynchronous active-low reset
//   bus   : sram_sub_ctrl_if.master (CPU, main SRAM, sub SRAM, Flash signals)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | ready for cpu_re / cpu_flush
// LOOKUP   | classify latched address: main read, sub hit or miss
// RESP     | capture main/sub read data, pulse cpu_rvalid
// EVICT    | walk the clock pointer, clearing ref bits until a victim found
// FILL_REQ | hold flash_req with the block base until flash_ack
// FILL     | write each Flash word into the victim slot, then replay lookup
// ----------------------------------------------------------------------------
module sram_sub_ctrl #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                SUB_NUM    = 4,
  parameter int                LOG_SUB    = 2,
  parameter int                SUB_DEPTH  = 256,
  parameter int                LOG_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] MAIN_LOWER = 'h0000_0000,
  parameter logic [ADDR_W-1:0] MAIN_UPPER = 'h0000_4000
) (
  input  logic           clk,
  input  logic           grst,
  sram_sub_ctrl_if.master bus
);

  localparam int                 TAG_W     = ADDR_W - LOG_DEPTH;
  localparam logic [ADDR_W-1:0]  MAIN_SPAN = MAIN_UPPER - MAIN_LOWER;
  localparam logic [LOG_DEPTH:0] CNT_LAST  = (LOG_DEPTH+1)'(SUB_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_RESP     = 3'd2,
    S_EVICT    = 3'd3,
    S_FILL_REQ = 3'd4,
    S_FILL     = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [SUB_NUM-1:0]   valid_q, valid_d;
  logic [SUB_NUM-1:0]   ref_q, ref_d;
  logic [TAG_W-1:0]     tag_q [SUB_NUM];
  logic [TAG_W-1:0]     tag_d [SUB_NUM];
  logic [LOG_SUB-1:0]   ptr_q, ptr_d;
  logic [LOG_SUB-1:0]   victim_q, victim_d;
  logic [LOG_DEPTH:0]   cnt_q, cnt_d;
  logic                 src_sub_q, src_sub_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;

  logic                 ready_c;
  logic                 main_re_c;
  logic                 sub_re_c;
  logic                 sub_we_c;
  logic [LOG_SUB-1:0]   sub_sel_c;
  logic [LOG_DEPTH-1:0] sub_addr_c;
  logic [DATA_W-1:0]    sub_wdata_c;
  logic                 flash_req_c;
  logic                 rmiss_c;

  logic [TAG_W-1:0]     addr_tag;
  logic [ADDR_W-1:0]    main_off;
  logic                 in_main;
  logic                 hit;
  logic [LOG_SUB-1:0]   hit_idx;

  assign addr_tag = addr_q[ADDR_W-1:LOG_DEPTH];
  // Offset-and-compare also rejects addresses below MAIN_LOWER, which wrap high.
  assign main_off = addr_q - MAIN_LOWER;
  assign in_main  = (main_off < MAIN_SPAN);

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < SUB_NUM; i++) begin
      if (!hit && valid_q[i] && (tag_q[i] == addr_tag)) begin
        hit     = 1'b1;
        hit_idx = LOG_SUB'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    ref_d       = ref_q;
    tag_d       = tag_q;
    ptr_d       = ptr_q;
    victim_d    = victim_q;
    cnt_d       = cnt_q;
    src_sub_d   = src_sub_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    ready_c     = 1'b0;
    main_re_c   = 1'b0;
    sub_re_c    = 1'b0;
    sub_we_c    = 1'b0;
    sub_sel_c   = '0;
    sub_addr_c  = '0;
    sub_wdata_c = '0;
    flash_req_c = 1'b0;
    rmiss_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.cpu_flush) begin
          valid_d = '0;
          ref_d   = '0;
          ptr_d   = '0;
        end else if (bus.cpu_re) begin
          addr_d  = bus.cpu_raddr;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (in_main) begin
          main_re_c = 1'b1;
          src_sub_d = 1'b0;
          state_d   = S_RESP;
        end else if (hit) begin
          sub_re_c       = 1'b1;
          sub_sel_c      = hit_idx;
          sub_addr_c     = addr_q[LOG_DEPTH-1:0];
          ref_d[hit_idx] = 1'b1;
          src_sub_d      = 1'b1;
          state_d        = S_RESP;
        end else begin
          rmiss_c = 1'b1;
          state_d = S_EVICT;
        end
      end

      S_RESP: begin
        rdata_d  = src_sub_q ? bus.sub_rdata : bus.main_rdata;
        rvalid_d = 1'b1;
        state_d  = S_IDLE;
      end

      S_EVICT: begin
        // Pointer advances on every visit, so a full sweep of set ref bits
        // brings it back to the first (now cleared) slot: at most SUB_NUM+1.
        ptr_d = ptr_q + 1'b1;
        if (valid_q[ptr_q] && ref_q[ptr_q]) begin
          ref_d[ptr_q] = 1'b0;
        end else begin
          victim_d       = ptr_q;
          valid_d[ptr_q] = 1'b0;
          state_d        = S_FILL_REQ;
        end
      end

      S_FILL_REQ: begin
        flash_req_c = 1'b1;
        if (bus.flash_ack) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        if (bus.flash_rvalid) begin
          sub_we_c    = 1'b1;
          sub_sel_c   = victim_q;
          sub_addr_c  = cnt_q[LOG_DEPTH-1:0];
          sub_wdata_c = bus.flash_rdata;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            tag_d[victim_q]   = addr_tag;
            valid_d[victim_q] = 1'b1;
            ref_d[victim_q]   = 1'b1;
            state_d           = S_LOOKUP;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge grst) begin
    if (!grst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      valid_q   <= '0;
      ref_q     <= '0;
      ptr_q     <= '0;
      victim_q  <= '0;
      cnt_q     <= '0;
      src_sub_q <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      ref_q     <= ref_d;
      ptr_q     <= ptr_d;
      victim_q  <= victim_d;
      cnt_q     <= cnt_d;
      src_sub_q <= src_sub_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Tags are only meaningful under valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  // cpu_ready is held low while reset is asserted even though state is IDLE.
  assign bus.cpu_ready  = ready_c & grst;
  assign bus.cpu_rvalid = rvalid_q;
  assign bus.cpu_rdata  = rdata_q;
  assign bus.cpu_rmiss  = rmiss_c;
  assign bus.main_re    = main_re_c;
  assign bus.main_addr  = main_re_c ? main_off : '0;
  assign bus.sub_re     = sub_re_c;
  assign bus.sub_sel    = sub_sel_c;
  assign bus.sub_addr   = sub_addr_c;
  assign bus.sub_we     = sub_we_c;
  assign bus.sub_wdata  = sub_wdata_c;
  assign bus.flash_req  = flash_req_c;
  assign bus.flash_addr = flash_req_c ? {addr_tag, {LOG_DEPTH{1'b0}}} : '0;

endmodule
